// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared definitions for the rv32i MEM stage.
//   - funct3 access-size codes for loads/stores
//   - access-size enum and decode helper
//   - MEM FSM state enum (IDLE / WAIT / ABORT)
//   - watchdog counter width
//   - misalignment helper, used only when MEM_MISALIGN_TRAP_EN is defined
package rv32i_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WCNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  // Unlisted funct3 codes fall back to a full word.
  function automatic mem_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_B;
      F3_H, F3_HU: f3_size = SZ_H;
      default:     f3_size = SZ_W;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3_size(f3))
      SZ_H:    f3_misaligned = lo[0];
      SZ_W:    f3_misaligned = |lo;
      default: f3_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the MEM stage.
//   funct3_i   access size / signedness (instruction[14:12])
//   addr_lo_i  low two bits of the effective address
//   sdata_i    raw store data from the register file
//   rdata_i    word returned by data memory
//   wdata_o    store data replicated across all lanes of the access size
//   mask_o     byte enables for the addressed lanes
//   ldata_o    selected load lane, sign- or zero-extended
// Low address bits beyond the access size are ignored: H uses addr[1],
// W always uses lane 0.
module mem_lane_align
  import rv32i_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  mask_o,
  output logic [31:0] ldata_o
);

  mem_size_e   sz;
  logic        uns;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  assign sz  = f3_size(funct3_i);
  assign uns = funct3_i[2];

  always_comb begin
    case (addr_lo_i)
      2'd0:    lbyte = rdata_i[7:0];
      2'd1:    lbyte = rdata_i[15:8];
      2'd2:    lbyte = rdata_i[23:16];
      default: lbyte = rdata_i[31:24];
    endcase
    lhalf = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    wdata_o = sdata_i;
    mask_o  = 4'b1111;
    ldata_o = rdata_i;
    case (sz)
      SZ_B: begin
        wdata_o = {4{sdata_i[7:0]}};
        mask_o  = 4'b0001 << addr_lo_i;
        ldata_o = uns ? {24'd0, lbyte} : {{24{lbyte[7]}}, lbyte};
      end
      SZ_H: begin
        wdata_o = {2{sdata_i[15:0]}};
        mask_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        ldata_o = uns ? {16'd0, lhalf} : {{16{lhalf[15]}}, lhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: rv32i MEM pipeline stage.
// Issues data-memory accesses over a req/ready handshake, stalls the front
// of the pipeline while memory is slow, aborts with a bus error when the
// wait watchdog expires, and registers the MEM/WB boundary.
//   clk, rst                      core clock, async active-high reset
//   load_in/store_in/reg_write_in EX/MEM control (load wins if both set)
//   mem_reg_in, alu_res_in, opb_data_in, next_sel_addr_in,
//   pre_address_in, instruction_in EX/MEM data; instruction_in[14:12] = size
//   dmem_*                        data-memory request / response
//   stall_out                     hold EX/MEM and earlier stages
//   *_out                         MEM/WB register; bus_err_out pulses on abort
// Optional: MEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into an
// immediate bus error with no memory request.
module memory_stage
  import rv32i_mem_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_in,
  input  logic        store_in,
  input  logic        reg_write_in,
  input  logic [1:0]  mem_reg_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] opb_data_in,
  input  logic [31:0] next_sel_addr_in,
  input  logic [31:0] pre_address_in,
  input  logic [31:0] instruction_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mask,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        reg_write_out,
  output logic [1:0]  mem_reg_out,
  output logic [31:0] load_data_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] next_sel_address_out,
  output logic [31:0] pre_address_out,
  output logic [31:0] instruction_out,
  output logic        bus_err_out
);

  mem_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  logic        access, is_store, misal;
  logic        req, complete, stall, abort, trap;
  logic [31:0] al_wdata, al_ldata;
  logic [3:0]  al_mask;

  assign access   = load_in | store_in;
  assign is_store = store_in & ~load_in;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = access & f3_misaligned(instruction_in[14:12], alu_res_in[1:0]);
`else
  assign misal = 1'b0;
`endif

  mem_lane_align u_align (
    .funct3_i  (instruction_in[14:12]),
    .addr_lo_i (alu_res_in[1:0]),
    .sdata_i   (opb_data_in),
    .rdata_i   (dmem_rdata),
    .wdata_o   (al_wdata),
    .mask_o    (al_mask),
    .ldata_o   (al_ldata)
  );

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    req      = 1'b0;
    complete = 1'b0;
    stall    = 1'b0;
    abort    = 1'b0;
    trap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wcnt_d = '0;
        if (access) begin
          if (misal) begin
            trap = 1'b1;
          end else begin
            req = 1'b1;
            if (dmem_ready) begin
              complete = 1'b1;
            end else begin
              stall   = 1'b1;
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        req = 1'b1;
        // A handshake on the last permitted wait cycle still wins over the abort.
        if (dmem_ready) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          stall  = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WCNT_W'(MAX_WAIT - 1)) state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        // Inputs still hold the aborted access; it retires this cycle.
        abort   = 1'b1;
        wcnt_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Request and stall are gated by rst so they drop the instant reset rises,
  // even though the IDLE-state request is driven straight from the inputs.
  assign dmem_req   = req & ~rst;
  assign dmem_we    = dmem_req & is_store;
  assign dmem_addr  = dmem_req ? {alu_res_in[31:2], 2'b00} : 32'd0;
  assign dmem_mask  = dmem_req ? al_mask : 4'd0;
  assign dmem_wdata = dmem_we ? al_wdata : 32'd0;
  assign stall_out  = stall & ~rst;

  // MEM/WB register
  logic        wb_rw_q, wb_err_q;
  logic [1:0]  wb_mreg_q;
  logic [31:0] wb_ld_q, wb_alu_q, wb_nsa_q, wb_pre_q, wb_ins_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rw_q   <= 1'b0;
      wb_err_q  <= 1'b0;
      wb_mreg_q <= '0;
      wb_ld_q   <= '0;
      wb_alu_q  <= '0;
      wb_nsa_q  <= '0;
      wb_pre_q  <= '0;
      wb_ins_q  <= '0;
    end else if (abort | trap) begin
      wb_rw_q   <= 1'b0;
      wb_err_q  <= 1'b1;
      wb_mreg_q <= mem_reg_in;
      wb_ld_q   <= '0;
      wb_alu_q  <= alu_res_in;
      wb_nsa_q  <= next_sel_addr_in;
      wb_pre_q  <= pre_address_in;
      wb_ins_q  <= instruction_in;
    end else if (stall) begin
      wb_rw_q   <= 1'b0;
      wb_err_q  <= 1'b0;
      wb_mreg_q <= '0;
      wb_ld_q   <= '0;
      wb_alu_q  <= '0;
      wb_nsa_q  <= '0;
      wb_pre_q  <= '0;
      wb_ins_q  <= '0;
    end else begin
      wb_rw_q   <= reg_write_in & ~is_store;
      wb_err_q  <= 1'b0;
      wb_mreg_q <= mem_reg_in;
      wb_ld_q   <= (complete & load_in) ? al_ldata : 32'd0;
      wb_alu_q  <= alu_res_in;
      wb_nsa_q  <= next_sel_addr_in;
      wb_pre_q  <= pre_address_in;
      wb_ins_q  <= instruction_in;
    end
  end

  assign reg_write_out        = wb_rw_q;
  assign bus_err_out          = wb_err_q;
  assign mem_reg_out          = wb_mreg_q;
  assign load_data_out        = wb_ld_q;
  assign alu_res_out          = wb_alu_q;
  assign next_sel_address_out = wb_nsa_q;
  assign pre_address_out      = wb_pre_q;
  assign instruction_out      = wb_ins_q;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_in = 0, store_in = 0, reg_write_in = 0;
  logic [1:0]  mem_reg_in = 0;
  logic [31:0] alu_res_in = 0, opb_data_in = 0, next_sel_addr_in = 0;
  logic [31:0] pre_address_in = 0, instruction_in = 0;
  logic        dmem_req, dmem_we, dmem_ready = 0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic [3:0]  dmem_mask;
  logic        stall_out, reg_write_out, bus_err_out;
  logic [1:0]  mem_reg_out;
  logic [31:0] load_data_out, alu_res_out, next_sel_address_out, pre_address_out, instruction_out;

  memory_stage #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .load_in(load_in), .store_in(store_in), .reg_write_in(reg_write_in),
    .mem_reg_in(mem_reg_in), .alu_res_in(alu_res_in), .opb_data_in(opb_data_in),
    .next_sel_addr_in(next_sel_addr_in), .pre_address_in(pre_address_in),
    .instruction_in(instruction_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_mask(dmem_mask),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out), .reg_write_out(reg_write_out), .mem_reg_out(mem_reg_out),
    .load_data_out(load_data_out), .alu_res_out(alu_res_out),
    .next_sel_address_out(next_sel_address_out), .pre_address_out(pre_address_out),
    .instruction_out(instruction_out), .bus_err_out(bus_err_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  mreg;
    logic [31:0] ld;
    logic [31:0] alu;
    logic [31:0] nsa;
    logic [31:0] pre;
    logic [31:0] ins;
    logic        berr;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   total = 0;
  int   bad   = 0;

  // MEM/WB monitor: any non-bubble entry must match the head of the queue.
  always @(negedge clk) begin
    wb_t got, exp;
    if (!rst && (reg_write_out || bus_err_out || instruction_out != 0)) begin
      got = '{reg_write_out, mem_reg_out, load_data_out, alu_res_out,
              next_sel_address_out, pre_address_out, instruction_out, bus_err_out};
      total++;
      if (wb_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got ins=%h rw=%b err=%b, required no entry", instruction_out, reg_write_out, bus_err_out);
      end else begin
        exp = wb_q.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL wb_entry ins=%h: got rw=%b mreg=%0d ld=%h alu=%h nsa=%h pre=%h err=%b, required rw=%b mreg=%0d ld=%h alu=%h nsa=%h pre=%h err=%b",
                   exp.ins, got.rw, got.mreg, got.ld, got.alu, got.nsa, got.pre, got.berr,
                   exp.rw, exp.mreg, exp.ld, exp.alu, exp.nsa, exp.pre, exp.berr);
        end
      end
    end
  end

  // Request monitor: every handshake must match the head of the request queue.
  always @(negedge clk) begin
    req_t got, exp;
    #2;
    if (dmem_req && dmem_ready) begin
      got = '{dmem_addr, dmem_we, dmem_mask, dmem_wdata};
      total++;
      if (req_q.size() == 0) begin
        bad++;
        $display("FAIL req_unexpected: got addr=%h, required no handshake", dmem_addr);
      end else begin
        exp = req_q.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL req_fields: got addr=%h we=%b mask=%b wdata=%h, required addr=%h we=%b mask=%b wdata=%h",
                   got.addr, got.we, got.mask, got.wdata, exp.addr, exp.we, exp.mask, exp.wdata);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    load_in = 0; store_in = 0; reg_write_in = 0; mem_reg_in = 0;
    alu_res_in = 0; opb_data_in = 0; next_sel_addr_in = 0; pre_address_in = 0;
    instruction_in = 0; dmem_ready = 0; dmem_rdata = 0;
  endtask

  // Called at a negedge. delay<0 means memory never answers.
  task automatic issue(input string name, input logic ld, input logic st, input logic rw,
                       input logic [31:0] alu, input logic [31:0] opb, input logic [31:0] ins,
                       input int delay, input logic [31:0] rdata,
                       input int est, input int ereq, input bit hs,
                       input logic [3:0] emask, input logic [31:0] ewdata,
                       input logic erw, input logic [31:0] eld, input logic eerr);
    int stalls = 0, reqs = 0;
    bit done = 0;
    load_in = ld; store_in = st; reg_write_in = rw; mem_reg_in = ins[5:4];
    alu_res_in = alu; opb_data_in = opb; instruction_in = ins;
    next_sel_addr_in = alu + 32'd4; pre_address_in = ~alu;
    if (hs) req_q.push_back('{{alu[31:2], 2'b00}, st & ~ld, emask, ewdata});
    wb_q.push_back('{erw, ins[5:4], eld, alu, alu + 32'd4, ~alu, ins, eerr});
    for (int c = 0; c < 600 && !done; c++) begin
      dmem_ready = (delay >= 0 && c == delay);
      dmem_rdata = rdata;
      #1;
      if (dmem_req) reqs++;
      if (stall_out) stalls++;
      done = !stall_out;
      @(negedge clk);
    end
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: stall never dropped, required completion", name);
    end
    idle_inputs();
    check({name, "_stalls"}, 64'(stalls), 64'(est));
    check({name, "_reqs"}, 64'(reqs), 64'(ereq));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {dmem_req, stall_out, reg_write_out, bus_err_out, instruction_out, load_data_out[29:0]},
          64'd0);
    rst = 0;
    @(negedge clk);

    // SW 0x104, zero wait; store never writes a register
    issue("sw", 0, 1, 1, 32'h104, 32'hDEADBEEF, 32'h00A12223, 0, 32'h0,
          0, 1, 1, 4'b1111, 32'hDEADBEEF, 0, 32'h0, 0);
    // LB 0x103, ready after 3 stall cycles
    issue("lb", 1, 0, 1, 32'h103, 32'h0, 32'h00010083, 3, 32'h80FFFF7F,
          3, 4, 1, 4'b1000, 32'h0, 1, 32'hFFFFFF80, 0);
    // LHU 0x102
    issue("lhu", 1, 0, 1, 32'h102, 32'h0, 32'h00015093, 1, 32'hBEEF1234,
          1, 2, 1, 4'b1100, 32'h0, 1, 32'h0000BEEF, 0);
    // SB 0xAB at 0x101
    issue("sb", 0, 1, 1, 32'h101, 32'h123456AB, 32'h00000023, 0, 32'h0,
          0, 1, 1, 4'b0010, 32'hABABABAB, 0, 32'h0, 0);
    // Watchdog abort: req high MW+1 cycles, then bus error entry
    issue("wdog", 1, 0, 1, 32'h200, 32'h0, 32'h000220A3, -1, 32'h0,
          MW + 1, MW + 1, 0, 4'b0, 32'h0, 0, 32'h0, 1);
    // Ready on the same cycle the counter hits the limit: handshake wins
    issue("lh_edge", 1, 0, 1, 32'h106, 32'h0, 32'h000010B3, MW, 32'h80010000,
          MW, MW + 1, 1, 4'b1100, 32'h0, 1, 32'hFFFF8001, 0);
    // Back-to-back: LW, then ALU op with stray ready, then SH
    issue("lw_b2b", 1, 0, 1, 32'h10, 32'h0, 32'h000020C3, 0, 32'h12345678,
          0, 1, 1, 4'b1111, 32'h0, 1, 32'h12345678, 0);
    issue("alu", 0, 0, 1, 32'h55, 32'h0, 32'h000000D3, 0, 32'hFFFFFFFF,
          0, 0, 0, 4'b0, 32'h0, 1, 32'h0, 0);
    issue("sh", 0, 1, 0, 32'h12, 32'h0000CAFE, 32'h000010E3, 2, 32'h0,
          2, 3, 1, 4'b1100, 32'hCAFECAFE, 0, 32'h0, 0);
    issue("lbu", 1, 0, 1, 32'h101, 32'h0, 32'h000040F3, 0, 32'h00009A00,
          0, 1, 1, 4'b0010, 32'h0, 1, 32'h0000009A, 0);
    // Load and store both set: treated as a load
    issue("ldst", 1, 1, 1, 32'h20, 32'h99999999, 32'h00002013, 0, 32'hCAFEF00D,
          0, 1, 1, 4'b1111, 32'h0, 1, 32'hCAFEF00D, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    issue("lw_mis", 1, 0, 1, 32'h102, 32'h0, 32'h00002023, 0, 32'h11223344,
          0, 0, 0, 4'b0, 32'h0, 0, 32'h0, 1);
`else
    issue("lw_mis", 1, 0, 1, 32'h102, 32'h0, 32'h00002023, 0, 32'h11223344,
          0, 1, 1, 4'b1111, 32'h0, 1, 32'h11223344, 0);
`endif

    // Reset in WAIT: request and stall drop immediately, access abandoned
    load_in = 1; reg_write_in = 1; alu_res_in = 32'h300; instruction_in = 32'h00002033;
    dmem_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    check("pre_reset_req_stall", {62'd0, dmem_req, stall_out}, 64'd3);
    rst = 1;
    #1;
    check("reset_req_stall", {62'd0, dmem_req, stall_out}, 64'd0);
    check("reset_wb", {reg_write_out, bus_err_out, mem_reg_out, instruction_out, alu_res_out[27:0]}, 64'd0);
    check("reset_ld", {32'd0, load_data_out | next_sel_address_out | pre_address_out}, 64'd0);
    @(negedge clk);
    idle_inputs();
    rst = 0;
    @(negedge clk);
    // After reset the next access starts from IDLE with zero wait
    issue("post_rst", 1, 0, 1, 32'h40, 32'h0, 32'h00002043, 0, 32'h0BADF00D,
          0, 1, 1, 4'b1111, 32'h0, 1, 32'h0BADF00D, 0);

    repeat (3) @(negedge clk);
    check("queues_drained", 64'(wb_q.size() + req_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage of the rv32i core; consumes the EX/MEM register outputs. Issues byte, half and word accesses to data memory over a req/ready handshake and stalls the front of the pipeline while memory is slow. Aligns and extends load data, and registers the MEM/WB boundary for the write-back stage.

## Interface
- MAX_WAIT, 255: wait-cycle watchdog limit before a bus-error abort (range 1..255).
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- load_in, store_in, reg_write_in  in  1 each  EX/MEM control bits.
- mem_reg_in  in  2  write-back select, passed through.
- alu_res_in  in  32  effective address, or ALU result for non-memory instructions.
- opb_data_in  in  32  store data.
- next_sel_addr_in, pre_address_in, instruction_in  in  32 each  passed through; instruction_in[14:12] gives access size.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address {alu_res_in[31:2], 2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_mask  out  4  byte enables.
- dmem_ready  in  1  memory accepts or completes the access this cycle.
- dmem_rdata  in  32  read word, valid when dmem_req && dmem_ready.
- stall_out  out  1  hold the EX/MEM register and earlier stages.
- reg_write_out  out  1  MEM/WB register.
- mem_reg_out  out  2  MEM/WB register.
- load_data_out, alu_res_out, next_sel_address_out, pre_address_out, instruction_out  out  32 each  MEM/WB register.
- bus_err_out  out  1  one-cycle pulse, aligned with the MEM/WB entry of the aborted access.

## Operation
- An access is load_in | store_in. If both are set, the access is treated as a load.
- FSM states:
  - IDLE: an access drives dmem_req combinationally.
    - If dmem_ready is also high, the access completes this cycle.
    - Otherwise go to WAIT.
  - WAIT: dmem_req stays high and the inputs are held stable by the stall.
    - Handshake (dmem_req && dmem_ready) completes the access and returns to IDLE.
    - The wait counter reaching MAX_WAIT forces ABORT.
  - ABORT: lasts one cycle. Deasserts dmem_req, returns to IDLE.
- stall_out is high when an access is present and not completing this cycle; it is low in ABORT.
- Size decode from funct3:
  - 000 = B, 001 = H, 010 = W, signed.
  - 100 = BU, 101 = HU.
  - Other codes are treated as W.
- Store lanes:
  - B: wdata = {4{b}}, mask = 1 << addr[1:0].
  - H: wdata = {2{h}}, mask = 0011 or 1100 selected by addr[1].
  - W: mask = 1111.
- Load: select the byte lane by addr[1:0] (halfword by addr[1]), then sign-extend or zero-extend per funct3. dmem_rdata is sampled only on the handshake cycle.
- MEM/WB register updates every cycle:
  - Completion or non-access: capture pass-through fields and load_data; reg_write_out = reg_write_in.
  - Stalling cycle: bubble. All fields 0, reg_write_out = 0.
  - Abort: pass-through fields captured, reg_write_out = 0, bus_err_out = 1.
- Store completion never writes a register, regardless of reg_write_in.
- Wait counter is 8 bits; it clears in IDLE and increments in WAIT.

## Timing
- Reset: every output and register is 0; the FSM is in IDLE.
  - dmem_req falls immediately on rst (asynchronous). An in-flight access is abandoned, with no completion and no error.
- Zero-wait access: the request and handshake occur in the same cycle, with no stall. MEM/WB outputs are valid after the next edge (latency 1).
- N wait cycles: stall_out is high for N cycles; the MEM/WB entry appears 1 cycle after the handshake.
- Abort: dmem_req is high for MAX_WAIT+1 cycles. bus_err_out pulses the cycle after ABORT.
- dmem_ready arriving in the same cycle the counter hits MAX_WAIT: the handshake wins and no abort occurs.
- dmem_ready while dmem_req is low: ignored.
- Back-to-back accesses: the next access may request in the cycle after completion.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned cases are H with addr[0] = 1, or W with addr[1:0] != 0.
  - For these, no dmem_req and no stall.
  - The MEM/WB entry has reg_write_out = 0 and bus_err_out = 1 on the next edge.
- MEM_MISALIGN_TRAP_EN undefined:
  - Low address bits are ignored per size: H uses addr[1] only, W uses lane 0.
  - The access proceeds normally, and bus_err_out signals only watchdog aborts.

## Structure
- Package rv32i_mem_pkg holds:
  - funct3 size constants;
  - the FSM state enum (IDLE, WAIT, ABORT);
  - the MAX_WAIT counter width.
- Sub-module mem_lane_align (combinational):
  - store wdata/mask generation;
  - load lane select and extension.
- FSM, watchdog and MEM/WB register stay in memory_stage.

## Test plan
- SW, addr 0x104, data 0xDEADBEEF, dmem_ready = 1 immediately -> mask 1111, addr 0x104, no stall; next cycle reg_write_out = 0.
- LB, addr 0x103, rdata 0x80FF_FF7F, ready after 3 cycles -> stall_out high 3 cycles, 3 bubbles, then load_data_out = 0xFFFFFF80, reg_write_out = 1.
- LHU, addr 0x102, rdata 0xBEEF1234 -> load_data_out = 0x0000BEEF. SB of 0xAB at addr 0x101 -> wdata 0xABABABAB, mask 0010.
- Watchdog: load with MAX_WAIT = 4, ready never asserted -> dmem_req high 5 cycles, bus_err_out pulse, reg_write_out = 0, stall drops.
- LW, addr 0x102 -> with MEM_MISALIGN_TRAP_EN: no req, bus_err_out = 1. Without it: req to 0x100, mask 1111.
- rst asserted in WAIT -> dmem_req, stall_out and all MEM/WB outputs go to 0 immediately. After release the next access starts from IDLE.
